// File: rtl/event_sched_pkg.sv
// rtl/event_sched_pkg.sv - shared types and constants for the event scheduler
package event_sched_pkg;

  localparam int DROP_W  = 16;
  localparam int EV_N_IN = 2;
  localparam int EV_TS_W = 32;

  // Default-width event record; the top re-declares it at its own parameter widths
  typedef struct packed {
    logic [EV_TS_W-1:0] ts;
    logic [EV_N_IN-1:0] in_mask;
    logic               per;
  } event_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/event_scheduler_if.sv
// rtl/event_scheduler_if.sv - event inputs, evaluator handshake and queue observation bundle
interface event_scheduler_if #(
  parameter int N_IN = 2,
  parameter int TS_W = 32
);
  import event_sched_pkg::*;

  logic              en;
  logic [N_IN-1:0]   new_input;
  logic              eval_ready;
  logic              eval_done;
  logic              q_push;
  logic              q_push_valid;
  logic              q_pop;
  logic              q_pop_valid;
  logic [N_IN-1:0]   pacing_in;
  logic              pacing_per;
  logic              slide;
  logic [TS_W-1:0]   ev_ts;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    input  en, new_input, eval_ready, eval_done,
    output q_push, q_push_valid, q_pop, q_pop_valid,
    output pacing_in, pacing_per, slide, ev_ts, busy, drop_cnt
  );

  modport slave (
    output en, new_input, eval_ready, eval_done,
    input  q_push, q_push_valid, q_pop, q_pop_valid,
    input  pacing_in, pacing_per, slide, ev_ts, busy, drop_cnt
  );

endinterface

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - synchronous event queue with wrap-bit pointers
module event_fifo
  import event_sched_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = event_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     data,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Caller only pushes when accepted and only pops when non-empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data;
  end

endmodule

// File: rtl/event_scheduler.sv
// rtl/event_scheduler.sv - merges input strobes and periodic deadlines into one issued event stream
// Optional saturating drop counter built when EVENT_SCHED_DROP_CNT_EN is defined.
module event_scheduler
  import event_sched_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 4,
  parameter int PERIOD = 500
) (
  input logic                clk,
  input logic                rst,
  event_scheduler_if.master  bus
);

  localparam int PW = $clog2(PERIOD);

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [N_IN-1:0] in_mask;
    logic            per;
  } rec_t;

  logic [TS_W-1:0] ts;
  logic [PW-1:0]   per_cnt;
  sched_state_t    state;
  rec_t            push_rec;
  rec_t            head;
  logic            full;
  logic            empty;
  logic            deadline;
  logic            push_ok;
  logic            pop_ok;

  logic [N_IN-1:0] pacing_in_q;
  logic            pacing_per_q;
  logic            slide_q;
  logic [TS_W-1:0] ev_ts_q;
  logic            busy_q;

  assign deadline = bus.en && (per_cnt == PW'(PERIOD - 1));

  // Gated by rst so every output reads 0 while reset is held
  assign bus.q_push       = rst && bus.en && ((|bus.new_input) || deadline);
  assign bus.q_pop        = rst && bus.en && bus.eval_ready && (state == IDLE);
  assign pop_ok           = bus.q_pop && !empty;
  assign push_ok          = bus.q_push && (!full || pop_ok);
  assign bus.q_pop_valid  = pop_ok;
  assign bus.q_push_valid = push_ok;

  assign push_rec.ts      = ts;
  assign push_rec.in_mask = bus.new_input;
  assign push_rec.per     = deadline;

  event_fifo #(
    .DEPTH (DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .data  (push_rec),
    .pop   (pop_ok),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts      <= '0;
      per_cnt <= '0;
    end else if (bus.en) begin
      ts      <= ts + TS_W'(1);
      per_cnt <= deadline ? '0 : per_cnt + PW'(1);
    end
  end

  // ISSUE always advances so a strobe never stretches past one cycle, even with en low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pacing_in_q  <= '0;
      pacing_per_q <= 1'b0;
      slide_q      <= 1'b0;
      ev_ts_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_ok) begin
            state        <= ISSUE;
            pacing_in_q  <= head.in_mask;
            pacing_per_q <= head.per;
            slide_q      <= head.per;
            ev_ts_q      <= head.ts;
            busy_q       <= 1'b1;
          end
        end
        ISSUE: begin
          state        <= WAIT;
          pacing_in_q  <= '0;
          pacing_per_q <= 1'b0;
          slide_q      <= 1'b0;
        end
        WAIT: begin
          if (bus.en && bus.eval_done) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          pacing_in_q  <= '0;
          pacing_per_q <= 1'b0;
          slide_q      <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pacing_in  = pacing_in_q;
  assign bus.pacing_per = pacing_per_q;
  assign bus.slide      = slide_q;
  assign bus.ev_ts      = ev_ts_q;
  assign bus.busy       = busy_q;

`ifdef EVENT_SCHED_DROP_CNT_EN
  logic              drop;
  logic [DROP_W-1:0] drop_q;

  assign drop = bus.q_push && !push_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_event_scheduler.sv
// tb/tb_event_scheduler.sv - directed checks of deadline, input issue, overflow and reset behaviour
module tb_event_scheduler;
  import event_sched_pkg::*;

  localparam int N_IN   = 2;
  localparam int TS_W   = 32;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 500;
`ifdef EVENT_SCHED_DROP_CNT_EN
  localparam int DROP_EXP = 2;
`else
  localparam int DROP_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  event_scheduler_if #(.N_IN(N_IN), .TS_W(TS_W)) bus ();

  event_scheduler #(
    .N_IN   (N_IN),
    .TS_W   (TS_W),
    .DEPTH  (DEPTH),
    .PERIOD (PERIOD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the start of cycle c (just after its opening edge)
  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.new_input = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_str;
    logic [TS_W-1:0] last_ts;

    bus.en         = 1'b1;
    bus.eval_ready = 1'b1;
    bus.eval_done  = 1'b1;
    bus.new_input  = '0;

    // Held in reset: everything reads zero
    repeat (2) @(posedge clk);
    smp;
    check_eq("rst_q_push", bus.q_push, 0);
    check_eq("rst_q_pop", bus.q_pop, 0);
    check_eq("rst_q_pop_valid", bus.q_pop_valid, 0);
    check_eq("rst_pacing_per", bus.pacing_per, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_ev_ts", bus.ev_ts, 0);
    check_eq("rst_drop", bus.drop_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;

    // Periodic deadline and a two-bit input event
    go(499); smp;
    check_eq("dl_q_push", bus.q_push, 1);
    check_eq("dl_q_push_valid", bus.q_push_valid, 1);
    go(500); smp;
    check_eq("dl_early", bus.pacing_per, 0);
    go(501); smp;
    check_eq("dl_pacing_per", bus.pacing_per, 1);
    check_eq("dl_slide", bus.slide, 1);
    check_eq("dl_ev_ts", bus.ev_ts, 499);
    check_eq("dl_busy", bus.busy, 1);
    go(502); smp;
    check_eq("dl_one_cycle", bus.pacing_per, 0);

    go(700); bus.new_input = 2'b11; smp;
    check_eq("in_q_push", bus.q_push, 1);
    check_eq("in_q_push_valid", bus.q_push_valid, 1);
    go(701); bus.new_input = 2'b00; smp;
    check_eq("in_q_pop", bus.q_pop, 1);
    check_eq("in_q_pop_valid", bus.q_pop_valid, 1);
    go(702); smp;
    check_eq("in_pacing_in", bus.pacing_in, 2'b11);
    check_eq("in_ev_ts", bus.ev_ts, 700);
    check_eq("in_no_per", bus.pacing_per, 0);
    go(703); smp;
    check_eq("in_wait_clear", bus.pacing_in, 0);
    check_eq("in_ev_ts_hold", bus.ev_ts, 700);

    go(1001); smp;
    check_eq("dl2_pacing_per", bus.pacing_per, 1);
    check_eq("dl2_ev_ts", bus.ev_ts, 999);

    // Input coincident with the deadline merges into one event
    do_reset;
    go(499); bus.new_input = 2'b01; smp;
    check_eq("co_q_push", bus.q_push, 1);
    go(500); bus.new_input = 2'b00;
    go(501); smp;
    check_eq("co_pacing_in", bus.pacing_in, 2'b01);
    check_eq("co_pacing_per", bus.pacing_per, 1);
    check_eq("co_ev_ts", bus.ev_ts, 499);
    n_str = 0;
    for (int c = 502; c <= 510; c++) begin
      go(c); smp;
      if ((|bus.pacing_in) || bus.pacing_per) n_str++;
    end
    check_eq("co_single_event", n_str, 0);

    // Overflow with evaluator stalled, then push/pop on a full queue
    do_reset;
    bus.eval_ready = 1'b0;
    for (int c = 10; c <= 15; c++) begin
      go(c); bus.new_input = 2'b01; smp;
      check_eq($sformatf("ov_push_valid_%0d", c), bus.q_push_valid, (c < 14) ? 1 : 0);
    end
    go(16); bus.new_input = 2'b00; smp;
    check_eq("ov_q_pop_stalled", bus.q_pop, 0);
    check_eq("ov_drop_cnt", bus.drop_cnt, DROP_EXP);
    go(20); bus.eval_ready = 1'b1; bus.new_input = 2'b01; smp;
    check_eq("full_pop_valid", bus.q_pop_valid, 1);
    check_eq("full_push_valid", bus.q_push_valid, 1);
    go(21); bus.new_input = 2'b00; smp;
    check_eq("full_first_ts", bus.ev_ts, 10);
    check_eq("full_drop_same", bus.drop_cnt, DROP_EXP);
    n_str = 1;
    last_ts = bus.ev_ts;
    for (int c = 22; c <= 40; c++) begin
      go(c); smp;
      if (|bus.pacing_in) begin
        n_str++;
        last_ts = bus.ev_ts;
      end
    end
    check_eq("full_event_count", n_str, 5);
    check_eq("full_last_ts", last_ts, 20);

    // Reset while waiting on the evaluator with entries queued
    do_reset;
    bus.eval_done = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      go(c); bus.new_input = 2'b01;
    end
    go(9); bus.new_input = 2'b00; smp;
    check_eq("rw_busy_before", bus.busy, 1);
    check_eq("rw_ev_ts_before", bus.ev_ts, 5);
    rst = 1'b0;
    #1;
    check_eq("rw_busy", bus.busy, 0);
    check_eq("rw_ev_ts", bus.ev_ts, 0);
    check_eq("rw_pacing_in", bus.pacing_in, 0);
    check_eq("rw_q_pop", bus.q_pop, 0);
    @(posedge clk);
    #1;
    bus.eval_done = 1'b1;
    rst = 1'b1;
    cyc = 0;
    n_str = 0;
    for (int c = 0; c <= 20; c++) begin
      go(c); smp;
      if (bus.q_pop_valid || (|bus.pacing_in) || bus.pacing_per) n_str++;
    end
    check_eq("rw_flushed", n_str, 0);
    go(25); bus.new_input = 2'b10;
    go(26); bus.new_input = 2'b00;
    go(27); smp;
    check_eq("rw_new_pacing", bus.pacing_in, 2'b10);
    check_eq("rw_new_ts", bus.ev_ts, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
